id: RTL and testbench
=====================

ID -- requirements
Module: ID

Interface
REQ-001 Parameter: BITSIZE, 32, register-file and operand data width.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 resetn_i  in  1  asynchronous active-low reset.
REQ-005 IF_ID_give_i  in  1  IF offers an instruction this cycle.
REQ-006 IF_ID_instr_i  in  32  instruction word from IF; sampled only on IF transfer.
REQ-007 ID_IF_get_o  out  1  ID can accept an instruction.
REQ-008 WB_ID_we_i  in  1  register-file write enable.
REQ-009 WB_ID_rd_i  in  5  write register index.
REQ-010 WB_ID_data_i  in  BITSIZE  write data.
REQ-011 EX_ID_get_i  in  1  EX can accept a decoded instruction.
REQ-012 ID_EX_give_o  out  1  decoded bundle valid.
REQ-013 ID_EX_opcode_o  out  7, ID_EX_funct3_o  out  3, ID_EX_funct7b5_o  out  1: instruction bits [6:0], [14:12], [30].
REQ-014 ID_EX_rd_o  out  5  destination index, bits [11:7].
REQ-015 ID_EX_rs1_data_o, ID_EX_rs2_data_o  out  BITSIZE  source operand values.
REQ-016 ID_EX_imm_o  out  BITSIZE  sign-extended immediate.
REQ-017 ID_EX_illegal_o  out  1  opcode not supported.

Function
REQ-018 FSM states WAIT_INSTR and PROVIDE; ID_IF_get_o = 1 iff WAIT_INSTR; ID_EX_give_o = 1 iff PROVIDE; both depend only on state (no combinational path from any input).
REQ-019 IF transfer: in WAIT_INSTR with IF_ID_give_i=1, instruction latched into instr register and next state PROVIDE; IF_ID_give_i=0 stays WAIT_INSTR.
REQ-020 EX transfer: in PROVIDE with EX_ID_get_i=1, next state WAIT_INSTR; otherwise hold PROVIDE with all ID_EX_* outputs stable.
REQ-021 Decode latency: bundle visible on ID_EX_* one cycle after IF transfer cycle; back-to-back throughput one instruction per two cycles.
REQ-022 Register file: 32 x BITSIZE; write on rising edge when WB_ID_we_i=1 and WB_ID_rd_i!=0; writes accepted in any state.
REQ-023 x0 reads always 0; writes to x0 ignored.
REQ-024 rs1/rs2 read combinationally from latched bits [19:15]/[24:20]; if WB_ID_we_i=1 and WB_ID_rd_i equals the nonzero source index, output WB_ID_data_i (same-cycle bypass).
REQ-025 Immediate by opcode: LUI/AUIPC U-type {instr[31:12],12'b0}; JAL J-type; JALR/LOAD/OP-IMM I-type; STORE S-type; BRANCH B-type (bit0=0); OP imm=0; all sign-extended from instr[31].
REQ-026 Supported opcodes 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011; any other sets ID_EX_illegal_o=1, imm=0, still handed to EX normally.
REQ-027 ID_EX_* data outputs are don't-care while ID_EX_give_o=0.

Reset
REQ-028 resetn_i low: state WAIT_INSTR, instr register 0, all 32 registers 0, ID_IF_get_o=1 after reset, ID_EX_give_o=0, immediately and asynchronously.
REQ-029 Reset during PROVIDE discards the held instruction; no EX transfer for it.
REQ-030 Deassertion: first IF transfer possible on first rising edge with resetn_i high.

Verification
REQ-031 IF gives 0x7C7FE2B7, EX_ID_get_i=1 -> next cycle give_o=1, opcode=0110111, rd=5, imm=0x7C7FE000; then get_o=1 again.
REQ-032 IF gives 0xFC7FE2B7 -> imm=0xFC7FE000; then 0x00118193 -> rd=3, funct3=0, imm=0x00000001, rs1_data=x3 current value.
REQ-033 Backpressure: EX_ID_get_i=0 for 5 cycles in PROVIDE -> give_o=1 and outputs constant, get_o=0, IF_ID_give_i ignored; get=1 -> WAIT_INSTR next cycle.
REQ-034 Bypass/x0: WB writes x3=0x12345678 during PROVIDE with rs1=3 -> rs1_data=0x12345678 same cycle; WB write x0=0xFFFFFFFF -> x0 reads 0.
REQ-035 Illegal 0x0000007F -> illegal=1, imm=0, give_o=1; reset asserted mid-PROVIDE -> give_o=0, get_o=1, all registers read 0.

Source files
------------

// File: rtl/id.sv
// Instruction decode stage: latches one instruction from IF, decodes it,
// reads the register file (with write-back bypass) and hands the bundle to EX.
module id #(
   parameter int BITSIZE = 32
) (
   input  logic               clk,
   input  logic               resetn_i,
   input  logic               IF_ID_give_i,
   input  logic [31:0]        IF_ID_instr_i,
   output logic               ID_IF_get_o,
   input  logic               WB_ID_we_i,
   input  logic [4:0]         WB_ID_rd_i,
   input  logic [BITSIZE-1:0] WB_ID_data_i,
   input  logic               EX_ID_get_i,
   output logic               ID_EX_give_o,
   output logic [6:0]         ID_EX_opcode_o,
   output logic [2:0]         ID_EX_funct3_o,
   output logic               ID_EX_funct7b5_o,
   output logic [4:0]         ID_EX_rd_o,
   output logic [BITSIZE-1:0] ID_EX_rs1_data_o,
   output logic [BITSIZE-1:0] ID_EX_rs2_data_o,
   output logic [BITSIZE-1:0] ID_EX_imm_o,
   output logic               ID_EX_illegal_o
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   typedef enum logic {
      WAIT_INSTR,
      PROVIDE
   } state_t;

   state_t             state;
   logic [31:0]        instr;
   logic [BITSIZE-1:0] regs [32];
   logic [4:0]         rs1;
   logic [4:0]         rs2;
   logic [31:0]        imm32;
   logic               illegal;

   always_ff @(posedge clk or negedge resetn_i) begin
      if (!resetn_i) begin
         state <= WAIT_INSTR;
         instr <= '0;
      end else begin
         unique case (state)
            WAIT_INSTR: begin
               if (IF_ID_give_i) begin
                  instr <= IF_ID_instr_i;
                  state <= PROVIDE;
               end
            end
            PROVIDE: begin
               if (EX_ID_get_i) state <= WAIT_INSTR;
            end
            default: state <= WAIT_INSTR;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn_i) begin
      if (!resetn_i) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (WB_ID_we_i && WB_ID_rd_i != 5'd0) begin
         regs[WB_ID_rd_i] <= WB_ID_data_i;
      end
   end

   assign ID_IF_get_o  = (state == WAIT_INSTR);
   assign ID_EX_give_o = (state == PROVIDE);

   assign rs1 = instr[19:15];
   assign rs2 = instr[24:20];

   // A write landing this cycle must be seen by the instruction being decoded.
   always_comb begin
      ID_EX_rs1_data_o = '0;
      if (rs1 != 5'd0) begin
         if (WB_ID_we_i && WB_ID_rd_i == rs1) ID_EX_rs1_data_o = WB_ID_data_i;
         else                                 ID_EX_rs1_data_o = regs[rs1];
      end
   end

   always_comb begin
      ID_EX_rs2_data_o = '0;
      if (rs2 != 5'd0) begin
         if (WB_ID_we_i && WB_ID_rd_i == rs2) ID_EX_rs2_data_o = WB_ID_data_i;
         else                                 ID_EX_rs2_data_o = regs[rs2];
      end
   end

   always_comb begin
      imm32   = '0;
      illegal = 1'b0;
      case (instr[6:0])
         OP_LUI, OP_AUIPC:
            imm32 = {instr[31:12], 12'b0};
         OP_JAL:
            imm32 = {{12{instr[31]}}, instr[19:12], instr[20],
                     instr[30:21], 1'b0};
         OP_JALR, OP_LOAD, OP_IMM:
            imm32 = {{20{instr[31]}}, instr[31:20]};
         OP_STORE:
            imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         OP_BRANCH:
            imm32 = {{20{instr[31]}}, instr[7], instr[30:25],
                     instr[11:8], 1'b0};
         OP_OP:
            imm32 = '0;
         default:
            illegal = 1'b1;
      endcase
   end

   assign ID_EX_opcode_o   = instr[6:0];
   assign ID_EX_funct3_o   = instr[14:12];
   assign ID_EX_funct7b5_o = instr[30];
   assign ID_EX_rd_o       = instr[11:7];
   assign ID_EX_imm_o      = BITSIZE'(signed'(imm32));
   assign ID_EX_illegal_o  = illegal;

endmodule

// File: tb/tb_id.sv
// Directed bench for the decode stage: vector table for the decoder
// plus sequences for backpressure, bypass, x0 and reset corners.
module tb_id;

   logic        clk = 1'b0;
   logic        resetn_i;
   logic        IF_ID_give_i;
   logic [31:0] IF_ID_instr_i;
   logic        ID_IF_get_o;
   logic        WB_ID_we_i;
   logic [4:0]  WB_ID_rd_i;
   logic [31:0] WB_ID_data_i;
   logic        EX_ID_get_i;
   logic        ID_EX_give_o;
   logic [6:0]  ID_EX_opcode_o;
   logic [2:0]  ID_EX_funct3_o;
   logic        ID_EX_funct7b5_o;
   logic [4:0]  ID_EX_rd_o;
   logic [31:0] ID_EX_rs1_data_o;
   logic [31:0] ID_EX_rs2_data_o;
   logic [31:0] ID_EX_imm_o;
   logic        ID_EX_illegal_o;

   int total  = 0;
   int passed = 0;

   id #(.BITSIZE(32)) dut (
      .clk              (clk),
      .resetn_i         (resetn_i),
      .IF_ID_give_i     (IF_ID_give_i),
      .IF_ID_instr_i    (IF_ID_instr_i),
      .ID_IF_get_o      (ID_IF_get_o),
      .WB_ID_we_i       (WB_ID_we_i),
      .WB_ID_rd_i       (WB_ID_rd_i),
      .WB_ID_data_i     (WB_ID_data_i),
      .EX_ID_get_i      (EX_ID_get_i),
      .ID_EX_give_o     (ID_EX_give_o),
      .ID_EX_opcode_o   (ID_EX_opcode_o),
      .ID_EX_funct3_o   (ID_EX_funct3_o),
      .ID_EX_funct7b5_o (ID_EX_funct7b5_o),
      .ID_EX_rd_o       (ID_EX_rd_o),
      .ID_EX_rs1_data_o (ID_EX_rs1_data_o),
      .ID_EX_rs2_data_o (ID_EX_rs2_data_o),
      .ID_EX_imm_o      (ID_EX_imm_o),
      .ID_EX_illegal_o  (ID_EX_illegal_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        b5;
      logic [31:0] imm;
      logic        ill;
   } vec_t;

   vec_t vt [14];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      else
         passed++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_hs(input string name, input logic get, input logic give);
      chk({name, "_get"}, 32'(ID_IF_get_o), 32'(get));
      chk({name, "_give"}, 32'(ID_EX_give_o), 32'(give));
   endtask

   initial begin
      vt[0]  = '{32'h7C7FE2B7, 7'h37, 5'd5,  3'd6, 1'b1, 32'h7C7FE000, 1'b0};
      vt[1]  = '{32'hFC7FE2B7, 7'h37, 5'd5,  3'd6, 1'b1, 32'hFC7FE000, 1'b0};
      vt[2]  = '{32'h00118193, 7'h13, 5'd3,  3'd0, 1'b0, 32'h00000001, 1'b0};
      vt[3]  = '{32'h0000007F, 7'h7F, 5'd0,  3'd0, 1'b0, 32'h00000000, 1'b1};
      vt[4]  = '{32'hFFF00093, 7'h13, 5'd1,  3'd0, 1'b1, 32'hFFFFFFFF, 1'b0};
      vt[5]  = '{32'hFE20AE23, 7'h23, 5'd28, 3'd2, 1'b1, 32'hFFFFFFFC, 1'b0};
      vt[6]  = '{32'hFE000CE3, 7'h63, 5'd25, 3'd0, 1'b1, 32'hFFFFFFF8, 1'b0};
      vt[7]  = '{32'hFFFFF0EF, 7'h6F, 5'd1,  3'd7, 1'b1, 32'hFFFFFFFE, 1'b0};
      vt[8]  = '{32'h12345517, 7'h17, 5'd10, 3'd5, 1'b0, 32'h12345000, 1'b0};
      vt[9]  = '{32'h402081B3, 7'h33, 5'd3,  3'd0, 1'b1, 32'h00000000, 1'b0};
      vt[10] = '{32'hFFF12283, 7'h03, 5'd5,  3'd2, 1'b1, 32'hFFFFFFFF, 1'b0};
      vt[11] = '{32'h00008067, 7'h67, 5'd0,  3'd0, 1'b0, 32'h00000000, 1'b0};
      vt[12] = '{32'hFFFFFFB3, 7'h33, 5'd31, 3'd7, 1'b1, 32'h00000000, 1'b0};
      vt[13] = '{32'hFFFFFF8B, 7'h0B, 5'd31, 3'd7, 1'b1, 32'h00000000, 1'b1};

      resetn_i      = 1'b0;
      IF_ID_give_i  = 1'b0;
      IF_ID_instr_i = '0;
      WB_ID_we_i    = 1'b0;
      WB_ID_rd_i    = '0;
      WB_ID_data_i  = '0;
      EX_ID_get_i   = 1'b0;
      #2;
      chk_hs("rst", 1'b1, 1'b0);
      tick();
      tick();
      resetn_i = 1'b1;
      #1;
      chk_hs("post_rst", 1'b1, 1'b0);

      // decoder table, EX always ready
      EX_ID_get_i = 1'b1;
      for (int i = 0; i < 14; i++) begin
         IF_ID_give_i  = 1'b1;
         IF_ID_instr_i = vt[i].instr;
         tick();
         IF_ID_give_i = 1'b0;
         chk_hs($sformatf("v%0d", i), 1'b0, 1'b1);
         chk($sformatf("v%0d_op", i), 32'(ID_EX_opcode_o), 32'(vt[i].op));
         chk($sformatf("v%0d_rd", i), 32'(ID_EX_rd_o), 32'(vt[i].rd));
         chk($sformatf("v%0d_f3", i), 32'(ID_EX_funct3_o), 32'(vt[i].f3));
         chk($sformatf("v%0d_b5", i), 32'(ID_EX_funct7b5_o), 32'(vt[i].b5));
         chk($sformatf("v%0d_imm", i), ID_EX_imm_o, vt[i].imm);
         chk($sformatf("v%0d_ill", i), 32'(ID_EX_illegal_o), 32'(vt[i].ill));
         tick();
         chk_hs($sformatf("v%0d_done", i), 1'b1, 1'b0);
      end

      // preload x3, x1 then hold a bundle under backpressure
      EX_ID_get_i  = 1'b0;
      WB_ID_we_i   = 1'b1;
      WB_ID_rd_i   = 5'd3;
      WB_ID_data_i = 32'hA5A5A5A5;
      tick();
      WB_ID_rd_i   = 5'd1;
      WB_ID_data_i = 32'h11111111;
      tick();
      WB_ID_we_i    = 1'b0;
      IF_ID_give_i  = 1'b1;
      IF_ID_instr_i = 32'h00118193;
      tick();
      IF_ID_instr_i = 32'h0000007F;
      chk("bp_rs1", ID_EX_rs1_data_o, 32'hA5A5A5A5);
      chk("bp_rs2", ID_EX_rs2_data_o, 32'h11111111);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk_hs($sformatf("bp%0d", c), 1'b0, 1'b1);
         chk($sformatf("bp%0d_imm", c), ID_EX_imm_o, 32'h00000001);
         chk($sformatf("bp%0d_op", c), 32'(ID_EX_opcode_o), 32'h13);
         chk($sformatf("bp%0d_ill", c), 32'(ID_EX_illegal_o), 32'h0);
      end
      IF_ID_give_i = 1'b0;
      WB_ID_we_i   = 1'b1;
      WB_ID_rd_i   = 5'd3;
      WB_ID_data_i = 32'h12345678;
      #1;
      chk("byp_rs1", ID_EX_rs1_data_o, 32'h12345678);
      tick();
      WB_ID_rd_i   = 5'd1;
      WB_ID_data_i = 32'hCAFEF00D;
      #1;
      chk("held_rs1", ID_EX_rs1_data_o, 32'h12345678);
      chk("byp_rs2", ID_EX_rs2_data_o, 32'hCAFEF00D);
      tick();
      WB_ID_we_i  = 1'b0;
      EX_ID_get_i = 1'b1;
      tick();
      chk_hs("bp_release", 1'b1, 1'b0);

      // x0 stays zero under write and bypass
      EX_ID_get_i   = 1'b0;
      IF_ID_give_i  = 1'b1;
      IF_ID_instr_i = 32'hFFF00093;
      tick();
      IF_ID_give_i = 1'b0;
      WB_ID_we_i   = 1'b1;
      WB_ID_rd_i   = 5'd0;
      WB_ID_data_i = 32'hFFFFFFFF;
      #1;
      chk("x0_byp", ID_EX_rs1_data_o, 32'h0);
      tick();
      WB_ID_we_i = 1'b0;
      #1;
      chk("x0_wr", ID_EX_rs1_data_o, 32'h0);
      EX_ID_get_i = 1'b1;
      tick();

      // fill and read back the whole register file
      WB_ID_we_i = 1'b1;
      for (int r = 1; r < 32; r++) begin
         WB_ID_rd_i   = 5'(r);
         WB_ID_data_i = 32'h01010101 * r;
         tick();
      end
      WB_ID_we_i = 1'b0;
      for (int r = 0; r < 32; r++) begin
         IF_ID_give_i  = 1'b1;
         IF_ID_instr_i = {7'b0, 5'(r), 5'(r), 3'b0, 5'd0, 7'h13};
         tick();
         IF_ID_give_i = 1'b0;
         chk($sformatf("rf%0d_rs1", r), ID_EX_rs1_data_o, 32'h01010101 * r);
         chk($sformatf("rf%0d_rs2", r), ID_EX_rs2_data_o, 32'h01010101 * r);
         tick();
      end

      // illegal opcode, then reset while it is held
      EX_ID_get_i   = 1'b0;
      IF_ID_give_i  = 1'b1;
      IF_ID_instr_i = 32'h0000007F;
      tick();
      IF_ID_give_i = 1'b0;
      chk_hs("ill", 1'b0, 1'b1);
      chk("ill_flag", 32'(ID_EX_illegal_o), 32'h1);
      chk("ill_imm", ID_EX_imm_o, 32'h0);
      #2;
      resetn_i = 1'b0;
      #1;
      chk_hs("mid_rst", 1'b1, 1'b0);
      tick();
      chk_hs("mid_rst_hold", 1'b1, 1'b0);
      resetn_i    = 1'b1;
      EX_ID_get_i = 1'b1;
      for (int r = 0; r < 32; r++) begin
         IF_ID_give_i  = 1'b1;
         IF_ID_instr_i = {7'b0, 5'(r), 5'(r), 3'b0, 5'd0, 7'h13};
         tick();
         IF_ID_give_i = 1'b0;
         chk($sformatf("clr%0d_give", r), 32'(ID_EX_give_o), 32'h1);
         chk($sformatf("clr%0d_rs1", r), ID_EX_rs1_data_o, 32'h0);
         chk($sformatf("clr%0d_rs2", r), ID_EX_rs2_data_o, 32'h0);
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
